// File: rtl/product_bcd_converter_if.sv
// +----------------------------------------------------------------------+
// | product_bcd_converter_if : start/result bundle of the BCD converter  |
// | Optional Blank lane when PRODUCT_BCD_BLANK_EN is defined.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface product_bcd_converter_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      product;
    logic                  busy;
    logic                  done;
    logic                  sign;
    logic [4*DIGITS-1:0]   digits;
`ifdef PRODUCT_BCD_BLANK_EN
    logic [DIGITS-1:0]     blank;

    modport master (output start, product, input busy, done, sign, digits, blank);
    modport slave  (input start, product, output busy, done, sign, digits, blank);
`else
    modport master (output start, product, input busy, done, sign, digits);
    modport slave  (input start, product, output busy, done, sign, digits);
`endif
endinterface

`default_nettype wire

// File: rtl/product_bcd_converter.sv
// +----------------------------------------------------------------------+
// | product_bcd_converter : sign + packed BCD of the multiplier product, |
// | iterative double-dabble, one bit per clock. Macro: PRODUCT_BCD_BLANK_EN|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module product_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter bit SIGNED = 1'b1
) (
    input  wire logic               clk_i,
    input  wire logic               reset_i,
    product_bcd_converter_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       bin_q, bin_d;
    logic [4*DIGITS-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   neg_q, neg_d;
    logic [4*DIGITS-1:0]    digits_q, digits_d;
    logic                   sign_q, sign_d;

    logic                   in_neg;
    logic [WIDTH-1:0]       mag;
    logic [4*DIGITS-1:0]    bcd_adj;
    logic [4*DIGITS+WIDTH-1:0] shifted;

    // Negation is taken modulo 2^WIDTH, so the most negative value maps to
    // its true magnitude as an unsigned number.
    always_comb begin
        in_neg = SIGNED ? bus.product[WIDTH-1] : 1'b0;
        mag    = in_neg ? (~bus.product + WIDTH'(1)) : bus.product;
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

`ifdef PRODUCT_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d, blank_calc;
    logic              zero_above;

    // Digit 0 is never blanked so a zero result still shows one "0".
    always_comb begin
        blank_calc = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above & (shifted[WIDTH + 4*i +: 4] == 4'd0);
            blank_calc[i] = zero_above;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        digits_d = digits_q;
        sign_d   = sign_q;
`ifdef PRODUCT_BCD_BLANK_EN
        blank_d  = blank_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    bin_d   = mag;
                    bcd_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    neg_d   = in_neg;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_d = shifted[WIDTH +: 4*DIGITS];
                bin_d = shifted[WIDTH-1:0];
                cnt_d = cnt_q - CW'(1);
                // Outputs change only here, on the last shift.
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    digits_d = shifted[WIDTH +: 4*DIGITS];
                    sign_d   = neg_q;
`ifdef PRODUCT_BCD_BLANK_EN
                    blank_d  = blank_calc;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            digits_q <= '0;
            sign_q   <= 1'b0;
`ifdef PRODUCT_BCD_BLANK_EN
            blank_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            digits_q <= digits_d;
            sign_q   <= sign_d;
`ifdef PRODUCT_BCD_BLANK_EN
            blank_q  <= blank_d;
`endif
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.sign   = sign_q;
    assign bus.digits = digits_q;
`ifdef PRODUCT_BCD_BLANK_EN
    assign bus.blank  = blank_q;
`endif

endmodule

`default_nettype wire

// File: doc/product_bcd_converter.md
Name: product_bcd_converter

Overview:
- Downstream stage of the 8-bit shift-add multiplier; consumes the 16-bit product {Aval,Bval} once the multiplier finishes.
- Converts the product (two's complement or unsigned) to sign plus packed BCD digits for decimal display on the board's 7-segment drivers.
- Iterative double-dabble: one bit per clock, start/done handshake, result held stable between conversions.

Parameters:
- WIDTH, 16, product width in bits.
- DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH.
- SIGNED, 1, 1 = product is two's complement, 0 = product is unsigned.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request conversion of Product; sampled only in IDLE.
- Product  input  WIDTH  value to convert, the multiplier's {Aval,Bval}; captured on the accepting edge.
- Busy  output  1  high in SHIFT and DONE states.
- Done  output  1  one-cycle pulse; result valid and newly updated.
- Sign  output  1  1 = negative result (SIGNED=1 only; tied 0 when SIGNED=0).
- Digits  output  4*DIGITS  packed BCD; [3:0] = ones, [7:4] = tens, and so on.

Behaviour:
- One clock (Clk); reset synchronous, active-high (Reset).
- Reset: state IDLE; Busy=0, Done=0, Sign=0, Digits=0; shift register and counter cleared. Reset mid-conversion aborts it; no Done is produced.
- States:
  - IDLE: Start=1 at edge k captures the magnitude into the shift register, clears the BCD field, sets count=WIDTH, and moves to SHIFT.
  - SHIFT: each edge applies add-3 to every BCD digit >= 5, then shifts {bcd,bin} left by 1 and decrements count. After the WIDTH-th shift, at edge k+WIDTH, moves to DONE.
  - DONE: Done=1 for exactly one cycle. At the next edge, returns to IDLE and Done=0.
- Output update: Digits and Sign update together at edge k+WIDTH (entry into DONE), and hold until the next DONE entry or Reset. Partial results are never visible on the outputs.
- Latency: Done is high in the cycle after edge k+WIDTH (17 cycles for WIDTH=16). Back-to-back throughput is one conversion per WIDTH+2 cycles.
- Start while Busy=1 (SHIFT or DONE) is ignored; it is not queued.
- Magnitude:
  - SIGNED=1: Sign=Product[WIDTH-1], and magnitude = two's-complement negate of Product when negative. The negate is taken as an unsigned WIDTH-bit value, so 0x8000 gives magnitude 32768 with no overflow.
  - SIGNED=0: magnitude = Product.
- The Product input may change freely after the accepting edge.
- Reset and Start in the same cycle: Reset wins.

Optional Feature:
- Macro: PRODUCT_BCD_BLANK_EN.
- Defined: adds an output port Blank (DIGITS bits, registered with Digits). Blank[i]=1 when digit i and every more-significant digit are zero, for i >= 1. Blank[0] is always 0, so value 0 displays a single "0". Blank resets to 0.
- Not defined: port Blank does not exist; downstream display shows all digits, including leading zeros.

Test Plan:
- Reset, then Start with Product=0x0000 -> Done after 17 cycles; Sign=0, Digits=0x00000; Busy high for exactly 17 cycles.
- Product=0xFE63 (0xC5 x 0x07 = -59 x 7 = -413) -> Sign=1, Digits=0x00413. With PRODUCT_BCD_BLANK_EN: Blank=5'b11000.
- Product=0x7FFF -> Sign=0, Digits=0x32767. Product=0x8000 -> Sign=1, Digits=0x32768.
- SIGNED=0, Product=0xFFFF -> Sign=0, Digits=0x65535.
- Start=1 held continuously with Product=0x0007 -> conversions complete every 18 cycles. Start pulses during SHIFT do not restart or shorten the conversion; Digits=0x00007.
- Start with Product=0x1234, then Reset asserted at shift 8 -> no Done, all outputs 0. A new Start with 0x0064 -> Digits=0x00100, Sign=0.
